corr_frame_sequencer: RTL and testbench

Readout sequencer between the correlator counter bank and the UART transmitter. On each integration-end pulse it walks every counter word in address order and emits a framed byte stream: header, payload, checksum. Bytes are handed to the byte-wide UART TX over a valid/ready handshake. Transmitting one byte at a time replaces a wide parallel snapshot register.

---
 rtl/corr_pkg.sv | 28 ++
 rtl/corr_tx_skid.sv | 56 +++++
 rtl/corr_frame_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_corr_frame_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// corr_pkg: definitions shared by the correlator readout path.
//   state_t               - readout sequencer states
//   SYNC_BYTE, HDR_BYTES  - frame header constants (the frame opens with the sync byte)
//   calc_num_words()      - counter words per frame: all baselines times lags, plus autos
//   calc_bytes_per_word() - bytes needed to carry one counter word
package corr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_BYTE,
    ST_CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h00;
  localparam int         HDR_BYTES = 4;

  function automatic int calc_num_words(input int num_inputs, input int delay_lines);
    return num_inputs * (num_inputs - 1) / 2 * delay_lines + num_inputs;
  endfunction

  function automatic int calc_bytes_per_word(input int resolution);
    return (resolution + 7) / 8;
  endfunction

endpackage

// File: rtl/corr_tx_skid.sv
// corr_tx_skid: one-entry output register towards the UART transmitter.
//   clk, reset_correlator - clock, asynchronous active-high reset
//   load, load_data       - present a new byte (only when empty or transferring)
//   clear_sum             - zero the running frame sum (frame start)
//   tx_ready              - UART accepts the presented byte
//   tx_data, tx_valid     - registered byte and valid flag
//   fire                  - a byte transfers this cycle
//   checksum              - value that closes the frame if the byte transferring
//                           now is the last payload byte
module corr_tx_skid (
  input  logic       clk,
  input  logic       reset_correlator,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       clear_sum,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       fire,
  output logic [7:0] checksum
);

  logic [7:0] data_reg;
  logic       valid_reg;
  logic [7:0] sum_reg;
  logic [7:0] total;

  assign fire     = valid_reg && tx_ready;
  assign tx_data  = data_reg;
  assign tx_valid = valid_reg;

  // The sum register lags one transfer behind, so fold in the byte leaving now.
  assign total    = sum_reg + data_reg;
  assign checksum = ~total + 8'd1;

  always_ff @(posedge clk or posedge reset_correlator) begin
    if (reset_correlator) begin
      data_reg  <= 8'h00;
      valid_reg <= 1'b0;
      sum_reg   <= 8'h00;
    end else begin
      if (load) begin
        data_reg  <= load_data;
        valid_reg <= 1'b1;
      end else if (fire) begin
        valid_reg <= 1'b0;
      end
      if (clear_sum) begin
        sum_reg <= 8'h00;
      end else if (fire) begin
        sum_reg <= sum_reg + data_reg;
      end
    end
  end

endmodule

// File: rtl/corr_frame_sequencer.sv
// corr_frame_sequencer: walks the correlator counter bank after each integration
// and streams header, payload words (little-endian) and checksum to the UART.
//   clk, reset_correlator     - clock, asynchronous active-high reset
//   frame_start               - end-of-integration pulse
//   transmit_enable           - frame permitted, sampled with frame_start
//   rd_en, rd_addr, rd_data   - counter bank read port (data one cycle after rd_en)
//   tx_data, tx_valid, tx_ready - byte handshake to the UART
//   busy                      - frame in progress
//   frame_done                - pulse the cycle after the checksum transfer
//   overrun_count             - frame_start pulses dropped while busy (saturating)
module corr_frame_sequencer
  import corr_pkg::*;
#(
  parameter  int RESOLUTION     = 8,
  parameter  int DELAY_LINES    = 51,
  parameter  int NUM_INPUTS     = 8,
  localparam int NUM_WORDS      = calc_num_words(NUM_INPUTS, DELAY_LINES),
  localparam int BYTES_PER_WORD = calc_bytes_per_word(RESOLUTION),
  localparam int ADDR_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_correlator,
  input  logic                  frame_start,
  input  logic                  transmit_enable,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [RESOLUTION-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            overrun_count
);

  localparam int                WORD_W    = BYTES_PER_WORD * 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [2:0]        BPW       = 3'(BYTES_PER_WORD);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   index_reg, index_next;
  logic [2:0]          hdr_cnt_reg, hdr_cnt_next;
  logic [2:0]          byte_cnt_reg, byte_cnt_next;
  logic [WORD_W-1:0]   word_reg, word_next;
  logic [7:0]          overrun_reg, overrun_next;
  logic                frame_done_reg, frame_done_next;

  logic                load;
  logic [7:0]          load_data;
  logic                clear_sum;
  logic                fire;
  logic [7:0]          checksum;
  logic [WORD_W-1:0]   rd_word_ext;

  assign rd_word_ext = WORD_W'(rd_data);

  function automatic logic [7:0] header_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return SYNC_BYTE;
      3'd1:    return 8'(DELAY_LINES);
      3'd2:    return 8'(NUM_INPUTS);
      default: return 8'(RESOLUTION);
    endcase
  endfunction

  corr_tx_skid u_tx_skid (
    .clk              (clk),
    .reset_correlator (reset_correlator),
    .load             (load),
    .load_data        (load_data),
    .clear_sum        (clear_sum),
    .tx_ready         (tx_ready),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .fire             (fire),
    .checksum         (checksum)
  );

  always_ff @(posedge clk or posedge reset_correlator) begin
    if (reset_correlator) begin
      state_reg      <= ST_IDLE;
      index_reg      <= '0;
      hdr_cnt_reg    <= 3'd0;
      byte_cnt_reg   <= 3'd0;
      word_reg       <= '0;
      overrun_reg    <= 8'h00;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      index_reg      <= index_next;
      hdr_cnt_reg    <= hdr_cnt_next;
      byte_cnt_reg   <= byte_cnt_next;
      word_reg       <= word_next;
      overrun_reg    <= overrun_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // hdr_cnt and byte_cnt count bytes already loaded into the output register,
  // so each accepted byte either loads the next one or ends the phase.
  always_comb begin
    state_next      = state_reg;
    index_next      = index_reg;
    hdr_cnt_next    = hdr_cnt_reg;
    byte_cnt_next   = byte_cnt_reg;
    word_next       = word_reg;
    overrun_next    = overrun_reg;
    frame_done_next = 1'b0;
    load            = 1'b0;
    load_data       = 8'h00;
    clear_sum       = 1'b0;

    if (frame_start && (state_reg != ST_IDLE) && (overrun_reg != 8'hFF)) begin
      overrun_next = overrun_reg + 8'd1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (frame_start && transmit_enable) begin
          load         = 1'b1;
          load_data    = SYNC_BYTE;
          clear_sum    = 1'b1;
          hdr_cnt_next = 3'd1;
          index_next   = '0;
          state_next   = ST_HDR;
        end
      end
      ST_HDR: begin
        if (fire) begin
          if (hdr_cnt_reg == 3'(HDR_BYTES)) begin
            state_next = ST_RD_REQ;
          end else begin
            load         = 1'b1;
            load_data    = header_byte(hdr_cnt_reg);
            hdr_cnt_next = hdr_cnt_reg + 3'd1;
          end
        end
      end
      ST_RD_REQ: begin
        state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // The output register is empty here, so the low byte goes straight out
        // and the shift register keeps the rest; this holds the word gap to
        // exactly the two read cycles.
        load          = 1'b1;
        load_data     = rd_word_ext[7:0];
        word_next     = rd_word_ext >> 8;
        byte_cnt_next = 3'd1;
        state_next    = ST_BYTE;
      end
      ST_BYTE: begin
        if (fire) begin
          if (byte_cnt_reg != BPW) begin
            load          = 1'b1;
            load_data     = word_reg[7:0];
            word_next     = word_reg >> 8;
            byte_cnt_next = byte_cnt_reg + 3'd1;
          end else if (index_reg == LAST_ADDR) begin
            load       = 1'b1;
            load_data  = checksum;
            state_next = ST_CSUM;
          end else begin
            index_next = index_reg + ADDR_W'(1);
            state_next = ST_RD_REQ;
          end
        end
      end
      ST_CSUM: begin
        if (fire) begin
          frame_done_next = 1'b1;
          index_next      = '0;
          state_next      = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rd_en         = (state_reg == ST_RD_REQ);
  assign rd_addr       = index_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign frame_done    = frame_done_reg;
  assign overrun_count = overrun_reg;

endmodule

// File: tb/tb_corr_frame_sequencer.sv
// tb_corr_frame_sequencer: two instances (default parameters and a small
// 12-bit / 2-input / 3-lag build). Expected frames are pushed to a byte queue
// when frame_start is driven and popped as the UART side accepts bytes.
module tb_corr_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_correlator;

  logic        b_frame_start, b_transmit_enable, b_rd_en, b_tx_valid, b_tx_ready, b_busy, b_frame_done;
  logic [10:0] b_rd_addr;
  logic [7:0]  b_rd_data, b_tx_data, b_overrun;

  logic        s_frame_start, s_transmit_enable, s_rd_en, s_tx_valid, s_tx_ready, s_busy, s_frame_done;
  logic [2:0]  s_rd_addr;
  logic [11:0] s_rd_data;
  logic [7:0]  s_tx_data, s_overrun;

  corr_frame_sequencer u_big (
    .clk (clk), .reset_correlator (reset_correlator),
    .frame_start (b_frame_start), .transmit_enable (b_transmit_enable),
    .rd_en (b_rd_en), .rd_addr (b_rd_addr), .rd_data (b_rd_data),
    .tx_data (b_tx_data), .tx_valid (b_tx_valid), .tx_ready (b_tx_ready),
    .busy (b_busy), .frame_done (b_frame_done), .overrun_count (b_overrun)
  );

  corr_frame_sequencer #(.RESOLUTION(12), .DELAY_LINES(3), .NUM_INPUTS(2)) u_small (
    .clk (clk), .reset_correlator (reset_correlator),
    .frame_start (s_frame_start), .transmit_enable (s_transmit_enable),
    .rd_en (s_rd_en), .rd_addr (s_rd_addr), .rd_data (s_rd_data),
    .tx_data (s_tx_data), .tx_valid (s_tx_valid), .tx_ready (s_tx_ready),
    .busy (s_busy), .frame_done (s_frame_done), .overrun_count (s_overrun)
  );

  logic [11:0] small_word;

  // Counter bank models: data valid only the cycle after rd_en, junk otherwise.
  always @(posedge clk) begin
    b_rd_data <= b_rd_en ? b_rd_addr[7:0] : 8'($urandom);
    s_rd_data <= s_rd_en ? small_word : 12'($urandom);
  end

  typedef struct {
    logic [11:0] word;
    int          stall_pct;
    int          exp_len;
    logic [7:0]  exp_csum;
  } vec_t;

  vec_t       vecs [4];
  int         checks = 0;
  int         failures = 0;
  logic       sel;
  logic [7:0] exp_q [$];
  logic       frame_active;
  logic [7:0] exp_ovr [2];
  int         frame_bytes, busy_cycles, idle_viol;
  logic [7:0] sum_all, last_byte;
  int         cur_exp_len;
  logic [7:0] cur_exp_csum;
  logic       prev_v, prev_r;
  logic [7:0] prev_d;
  logic       cur_v, cur_b, cur_fd;
  logic [7:0] cur_d, cur_ovr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push_frame();
    logic [7:0]  hdr [4];
    logic [7:0]  sum, b;
    logic [31:0] w;
    int          nw, bpw;
    if (sel) begin
      hdr = '{8'h00, 8'h03, 8'h02, 8'h0C}; nw = 5; bpw = 2;
    end else begin
      hdr = '{8'h00, 8'h33, 8'h08, 8'h08}; nw = 1436; bpw = 1;
    end
    sum = 8'h00;
    foreach (hdr[i]) begin
      exp_q.push_back(hdr[i]);
      sum += hdr[i];
    end
    for (int a = 0; a < nw; a++) begin
      w = sel ? 32'(small_word) : 32'(a % 256);
      for (int k = 0; k < bpw; k++) begin
        b = 8'(w >> (8 * k));
        exp_q.push_back(b);
        sum += b;
      end
    end
    exp_q.push_back(8'h00 - sum);
  endtask

  task automatic step(input logic fs, input logic te, input int stall_pct);
    logic       tr;
    logic [7:0] e;
    @(negedge clk);
    tr = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= 32'(stall_pct));
    b_frame_start = fs && !sel;
    s_frame_start = fs && sel;
    b_transmit_enable = te;
    s_transmit_enable = te;
    b_tx_ready = tr;
    s_tx_ready = tr;
    if (fs && te && !frame_active) begin
      push_frame();
      frame_active = 1'b1;
      frame_bytes = 0;
      busy_cycles = 0;
      sum_all = 8'h00;
    end else if (fs && frame_active && exp_ovr[sel] != 8'hFF) begin
      exp_ovr[sel] = exp_ovr[sel] + 8'd1;
    end
    cur_v   = sel ? s_tx_valid   : b_tx_valid;
    cur_d   = sel ? s_tx_data    : b_tx_data;
    cur_b   = sel ? s_busy       : b_busy;
    cur_fd  = sel ? s_frame_done : b_frame_done;
    cur_ovr = sel ? s_overrun    : b_overrun;
    if (prev_v && !prev_r) begin
      chk("stall_valid_hold", 32'(cur_v), 32'(1'b1));
      chk("stall_data_hold", 32'(cur_d), 32'(prev_d));
    end
    if (cur_b) busy_cycles++;
    if (!frame_active && (cur_v || cur_b)) idle_viol++;
    if (cur_v && tr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", 32'(cur_d), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("stream_byte", 32'(cur_d), 32'(e));
      end
      frame_bytes++;
      sum_all += cur_d;
      last_byte = cur_d;
    end
    if (cur_fd) begin
      chk("done_expected", 32'(frame_active), 32'(1'b1));
      if (frame_active) begin
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("frame_len", 32'(frame_bytes), 32'(cur_exp_len));
        chk("frame_sum", 32'(sum_all), 32'd0);
        chk("checksum", 32'(last_byte), 32'(cur_exp_csum));
        $display("frame sel=%0d bytes=%0d csum=%02h overrun=%0d", sel, frame_bytes, last_byte, cur_ovr);
      end
      frame_active = 1'b0;
    end
    prev_v = cur_v;
    prev_r = tr;
    prev_d = cur_d;
  endtask

  task automatic run_frame(input int stall_pct, input logic te_after, input int pulses,
                           input int exp_busy, input int budget);
    int n;
    int left;
    logic fs;
    step(1'b1, 1'b1, stall_pct);
    step(1'b0, te_after, stall_pct);
    chk("start_busy", 32'(cur_b), 32'(1'b1));
    chk("start_valid", 32'(cur_v), 32'(1'b1));
    chk("start_sync", 32'(cur_d), 32'h00);
    n = 0;
    left = pulses;
    while (frame_active && n < budget) begin
      fs = (left > 0) && (n >= 4) && (n % 2 == 0);
      if (fs) left--;
      step(fs, te_after, stall_pct);
      n++;
    end
    if (frame_active) begin
      chk("frame_timeout", 32'(n), 32'(budget + 1));
      frame_active = 1'b0;
      exp_q.delete();
    end
    if (exp_busy >= 0) chk("busy_cycles", 32'(busy_cycles), 32'(exp_busy));
    chk("overrun_count", 32'(cur_ovr), 32'(exp_ovr[sel]));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(b_rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(b_rd_addr), 32'd0);
    chk({tag, "_tx_data"}, 32'(b_tx_data), 32'd0);
    chk({tag, "_tx_valid"}, 32'(b_tx_valid), 32'd0);
    chk({tag, "_busy"}, 32'(b_busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(b_frame_done), 32'd0);
    chk({tag, "_overrun"}, 32'(b_overrun), 32'd0);
    chk({tag, "_small_valid_busy"}, 32'({s_tx_valid, s_busy}), 32'd0);
  endtask

  initial begin
    // word, stall %, frame length, checksum (hand-derived: header sum 0x11 + 5 words)
    vecs[0] = '{12'hABC, 0,  15, 8'h11};
    vecs[1] = '{12'h000, 30, 15, 8'hEF};
    vecs[2] = '{12'hFFF, 30, 15, 8'hA9};
    vecs[3] = '{12'h123, 50, 15, 8'h3B};

    reset_correlator = 1'b1;
    b_frame_start = 1'b0; s_frame_start = 1'b0;
    b_transmit_enable = 1'b0; s_transmit_enable = 1'b0;
    b_tx_ready = 1'b0; s_tx_ready = 1'b0;
    small_word = 12'h000;
    sel = 1'b0;
    frame_active = 1'b0;
    exp_ovr = '{8'h00, 8'h00};
    idle_viol = 0; frame_bytes = 0; busy_cycles = 0;
    sum_all = 8'h00; last_byte = 8'h00;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_correlator = 1'b0;

    // Default build, no stalls: 1441 bytes, payload addr[7:0], checksum 0x03.
    sel = 1'b0; cur_exp_len = 1441; cur_exp_csum = 8'h03;
    run_frame(0, 1'b1, 0, 4313, 6000);

    // Small build, table of words and stall rates.
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      small_word = vecs[i].word;
      cur_exp_len = vecs[i].exp_len;
      cur_exp_csum = vecs[i].exp_csum;
      run_frame(vecs[i].stall_pct, 1'b1, 0, (vecs[i].stall_pct == 0) ? 25 : -1, 2000);
    end

    // Default build, 30% stalls, transmit_enable dropped mid-frame, 3 overruns.
    sel = 1'b0; cur_exp_len = 1441; cur_exp_csum = 8'h03;
    run_frame(30, 1'b0, 3, -1, 12000);
    chk("overrun_three", 32'(b_overrun), 32'd3);

    // transmit_enable low at frame_start: nothing happens.
    sel = 1'b1; idle_viol = 0;
    step(1'b1, 1'b0, 0);
    repeat (20) step(1'b0, 1'b0, 0);
    chk("disabled_idle", 32'(idle_viol), 32'd0);
    chk("disabled_overrun", 32'(s_overrun), 32'd0);

    // 300 pulses during a frame saturate the overrun counter.
    sel = 1'b0;
    run_frame(0, 1'b1, 300, 4313, 6000);
    chk("overrun_saturated", 32'(b_overrun), 32'hFF);

    // Asynchronous reset mid-payload, then a clean frame.
    step(1'b1, 1'b1, 0);
    repeat (50) step(1'b0, 1'b1, 0);
    chk("pre_reset_busy", 32'(b_busy), 32'd1);
    @(negedge clk);
    #2 reset_correlator = 1'b1;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    frame_active = 1'b0;
    exp_ovr = '{8'h00, 8'h00};
    prev_v = 1'b0;
    repeat (2) @(negedge clk);
    reset_correlator = 1'b0;
    run_frame(0, 1'b1, 0, 4313, 6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
